// File: rtl/demux_pkg.sv
// Shared constants and types for the 1:2 demultiplexer and its lane FIFOs.
package demux_pkg;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Lane index: 0 selects lane 0, 1 selects lane 1.
  typedef logic lane_t;

endpackage

// File: rtl/demux_lane_fifo.sv
// Single-lane FIFO with wrap-bit pointers, zero head when empty and underflow protection.
module demux_lane_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               pop_ok, push_ok;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]) && (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
    pop_ok  = pop && !empty;
    // A full lane still takes a word when the head leaves in the same cycle.
    push_ok = push && (!full || pop_ok);
    head    = empty ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q[PtrW-1:0]] <= push_data;
  end

endmodule

// File: rtl/demux12_2bits.sv
// Registered 1:2 demultiplexer: steers each accepted word into one of two buffered lanes.
module demux12_2bits
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = demux_pkg::WIDTH,
  parameter int unsigned DEPTH = demux_pkg::DEPTH,
  parameter int unsigned CNT_W = demux_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  lane_t            selector,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out0,
  output logic             valid_out0,
  input  logic             pop0,
  output logic [WIDTH-1:0] data_out1,
  output logic             valid_out1,
  input  logic             pop1,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1
);

  logic             empty0, empty1, full0, full1;
  logic             accept, push0, push1, lane_pop0, lane_pop1;
  logic [CNT_W-1:0] count0_q, count1_q;

  always_comb begin
    // Only the selected lane can stall the producer.
    ready_out = selector ? (!full1 || pop1) : (!full0 || pop0);
    accept    = valid_in && ready_out && !reset;
    push0     = accept && (selector == 1'b0);
    push1     = accept && (selector == 1'b1);
    lane_pop0 = pop0 && !reset;
    lane_pop1 = pop1 && !reset;
  end

  demux_lane_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lane0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (data_in),
    .pop       (lane_pop0),
    .head      (data_out0),
    .empty     (empty0),
    .full      (full0)
  );

  demux_lane_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lane1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (data_in),
    .pop       (lane_pop1),
    .head      (data_out1),
    .empty     (empty1),
    .full      (full1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      if (push0) count0_q <= count0_q + CNT_W'(1);
      if (push1) count1_q <= count1_q + CNT_W'(1);
    end
  end

  assign valid_out0 = !empty0;
  assign valid_out1 = !empty1;
  assign count0     = count0_q;
  assign count1     = count1_q;

endmodule

// File: tb/tb_demux12_2bits.sv
// Self-checking bench for demux12_2bits against a queue-based lane model.
module tb_demux12_2bits;

  localparam int unsigned Depth = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       selector = 1'b0;
  logic       valid_in = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic       ready_out;
  logic [1:0] data_out0, data_out1;
  logic       valid_out0, valid_out1;
  logic       pop0 = 1'b0, pop1 = 1'b0;
  logic [7:0] count0, count1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  bit   [7:0] m_cnt0 = 8'd0, m_cnt1 = 8'd0;

  always #5 clk = ~clk;

  demux12_2bits dut (
    .clk        (clk),
    .reset      (reset),
    .selector   (selector),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .ready_out  (ready_out),
    .data_out0  (data_out0),
    .valid_out0 (valid_out0),
    .pop0       (pop0),
    .data_out1  (data_out1),
    .valid_out1 (valid_out1),
    .pop1       (pop1),
    .count0     (count0),
    .count1     (count1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("valid_out0", {31'd0, valid_out0}, {31'd0, q0.size() != 0});
    check("data_out0", {30'd0, data_out0}, (q0.size() != 0) ? {30'd0, q0[0]} : 32'd0);
    check("valid_out1", {31'd0, valid_out1}, {31'd0, q1.size() != 0});
    check("data_out1", {30'd0, data_out1}, (q1.size() != 0) ? {30'd0, q1[0]} : 32'd0);
    check("count0", {24'd0, count0}, {24'd0, m_cnt0});
    check("count1", {24'd0, count1}, {24'd0, m_cnt1});
  endtask

  // One clock: drive, check ready, advance the model at the edge, check outputs.
  task automatic do_cycle(input logic rst, input logic sel, input logic vin,
                          input logic [1:0] d, input logic p0, input logic p1);
    logic exp_ready;
    reset = rst; selector = sel; valid_in = vin; data_in = d; pop0 = p0; pop1 = p1;
    #1;
    exp_ready = sel ? ((q1.size() < Depth) || p1) : ((q0.size() < Depth) || p0);
    check("ready_out", {31'd0, ready_out}, {31'd0, exp_ready});
    @(posedge clk);
    if (rst) begin
      q0.delete(); q1.delete();
      m_cnt0 = 8'd0; m_cnt1 = 8'd0;
    end else begin
      if (p0 && q0.size() > 0) void'(q0.pop_front());
      if (p1 && q1.size() > 0) void'(q1.pop_front());
      if (vin && exp_ready) begin
        if (sel) begin q1.push_back(d); m_cnt1++; end
        else     begin q0.push_back(d); m_cnt0++; end
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    // Reset, then a single word to lane 1.
    do_cycle(1, 0, 0, 2'b00, 0, 0);
    do_cycle(1, 0, 0, 2'b00, 0, 0);
    check("rst_ready", {31'd0, ready_out}, 32'd1);
    do_cycle(0, 1, 1, 2'b10, 0, 0);
    check("t1_valid1", {31'd0, valid_out1}, 32'd1);
    check("t1_data1", {30'd0, data_out1}, 32'd2);
    check("t1_valid0", {31'd0, valid_out0}, 32'd0);
    check("t1_count1", {24'd0, count1}, 32'd1);

    // Alternating selector fills both lanes; fifth word to lane 0 stalls.
    do_cycle(1, 0, 0, 2'b00, 0, 0);
    do_cycle(0, 0, 1, 2'b01, 0, 0);
    do_cycle(0, 1, 1, 2'b10, 0, 0);
    do_cycle(0, 0, 1, 2'b11, 0, 0);
    do_cycle(0, 1, 1, 2'b00, 0, 0);
    do_cycle(0, 0, 1, 2'b10, 0, 0);
    check("t2_count0", {24'd0, count0}, 32'd2);
    check("t2_count1", {24'd0, count1}, 32'd2);
    check("t2_head0", {30'd0, data_out0}, 32'd1);

    // Lane isolation: drain lane 0, lane 1 stays full, push to lane 0.
    do_cycle(0, 0, 0, 2'b00, 1, 0);
    do_cycle(0, 0, 0, 2'b00, 1, 0);
    do_cycle(0, 0, 1, 2'b11, 0, 0);
    check("t3_data0", {30'd0, data_out0}, 32'd3);

    // Full lane 0 with simultaneous push and pop.
    do_cycle(1, 0, 0, 2'b00, 0, 0);
    do_cycle(0, 0, 1, 2'b01, 0, 0);
    do_cycle(0, 0, 1, 2'b10, 0, 0);
    do_cycle(0, 0, 1, 2'b11, 1, 0);
    check("t4_head_a", {30'd0, data_out0}, 32'd2);
    do_cycle(0, 0, 0, 2'b00, 1, 0);
    check("t4_head_b", {30'd0, data_out0}, 32'd3);
    do_cycle(0, 0, 0, 2'b00, 1, 0);
    check("t4_empty", {31'd0, valid_out0}, 32'd0);

    // Pops on an empty lane 1 must not disturb its pointers.
    for (int i = 0; i < 3; i++) do_cycle(0, 1, 0, 2'b00, 0, 1);
    do_cycle(0, 1, 1, 2'b01, 0, 0);
    check("t5_data1", {30'd0, data_out1}, 32'd1);

    // Counter wrap after 256 words, then reset with lane 1 occupied.
    do_cycle(1, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 256; i++) do_cycle(0, 0, 1, 2'($urandom), 1, 0);
    check("t6_wrap", {24'd0, count0}, 32'd0);
    do_cycle(0, 1, 1, 2'b11, 0, 0);
    do_cycle(1, 0, 1, 2'b01, 1, 1);
    check("t6_valid1", {31'd0, valid_out1}, 32'd0);
    check("t6_data1", {30'd0, data_out1}, 32'd0);
    check("t6_count1", {24'd0, count1}, 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      do_cycle(($urandom_range(0, 63) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
               2'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
